// File: rtl/alu_reg_bank.sv
// Register bank feeding an ALU: a one-cycle operand fetch port and a write-back port.
// Each double-width result is written over two cycles (low half, then high half) by a 3-state FSM.
module alu_reg_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [ADDR_W-1:0]    op_addr_a,
    input  logic [ADDR_W-1:0]    op_addr_b,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 ab_valid,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [ADDR_W-1:0]    res_addr,
    input  logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_t;

    wb_state_t               state_q, state_d;
    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [WIDTH-1:0]        cap_lo_q, cap_lo_d;
    logic [WIDTH-1:0]        cap_hi_q, cap_hi_d;
    logic [ADDR_W-1:0]       cap_addr_q, cap_addr_d;
    logic [WIDTH-1:0]        a_q, a_d, b_q, b_d, y_q, y_d;
    logic                    ab_valid_q, ab_valid_d;
    logic                    op_ready_q, op_ready_d;

    logic                    res_ready_s;
    logic                    capture_s;
    logic                    wr_en_s;
    logic                    wr_hi_s;
    logic [ADDR_W-1:0]       wr_addr_s;
    logic [WIDTH-1:0]        wr_data_s;
    logic                    fetch_s;

    // A read that collides with the write of this same edge returns the incoming data.
    function automatic logic [WIDTH-1:0] fwd_read(
        input logic [WIDTH-1:0]  rd_data,
        input logic [ADDR_W-1:0] rd_addr,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata
    );
        if (wen && (rd_addr == waddr)) begin
            return wdata;
        end else begin
            return rd_data;
        end
    endfunction

    // Write-back FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-back FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    state_d = WR_LO;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_LO:   state_d = WR_HI;
            WR_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-back FSM outputs
    always_comb begin
        res_ready_s = 1'b0;
        capture_s   = 1'b0;
        wr_en_s     = 1'b0;
        wr_hi_s     = 1'b0;
        case (state_q)
            IDLE: begin
                res_ready_s = 1'b1;
                capture_s   = res_valid;
            end
            WR_LO: begin
                wr_en_s = 1'b1;
                wr_hi_s = 1'b0;
            end
            WR_HI: begin
                wr_en_s = 1'b1;
                wr_hi_s = 1'b1;
            end
            default: begin
                res_ready_s = 1'b0;
                capture_s   = 1'b0;
            end
        endcase
    end

    // Write port decode; the high-half address wraps because DEPTH is a power of two
    always_comb begin
        if (wr_hi_s) begin
            wr_addr_s = cap_addr_q + ADDR_W'(1);
            wr_data_s = cap_hi_q;
        end else begin
            wr_addr_s = cap_addr_q;
            wr_data_s = cap_lo_q;
        end
    end

    // Next-state for captured result, register file, fetch and y
    always_comb begin
        if (capture_s) begin
            cap_lo_d   = result[WIDTH-1:0];
            cap_hi_d   = result[2*WIDTH-1:WIDTH];
            cap_addr_d = res_addr;
        end else begin
            cap_lo_d   = cap_lo_q;
            cap_hi_d   = cap_hi_q;
            cap_addr_d = cap_addr_q;
        end

        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[wr_addr_s] = wr_data_s;
        end else begin
            regs_d = regs_q;
        end

        fetch_s    = op_valid && op_ready_q;
        ab_valid_d = fetch_s;
        op_ready_d = 1'b1;
        if (fetch_s) begin
            a_d = fwd_read(regs_q[op_addr_a], op_addr_a, wr_en_s, wr_addr_s, wr_data_s);
            b_d = fwd_read(regs_q[op_addr_b], op_addr_b, wr_en_s, wr_addr_s, wr_data_s);
        end else begin
            a_d = a_q;
            b_d = b_q;
        end

        if (wr_en_s && !wr_hi_s) begin
            y_d = wr_data_s;
        end else begin
            y_d = y_q;
        end
    end

    // Datapath registers; reset clears everything and blocks any write or fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            cap_lo_q   <= '0;
            cap_hi_q   <= '0;
            cap_addr_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            ab_valid_q <= 1'b0;
            op_ready_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cap_lo_q   <= cap_lo_d;
            cap_hi_q   <= cap_hi_d;
            cap_addr_q <= cap_addr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            y_q        <= y_d;
            ab_valid_q <= ab_valid_d;
            op_ready_q <= op_ready_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign a         = a_q;
    assign b         = b_q;
    assign ab_valid  = ab_valid_q;
    assign res_ready = res_ready_s;
    assign y         = y_q;

endmodule
